// File: rtl/reg_write_back_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_write_back_arbiter_if
//
// Purpose: bundles every non-clock/reset signal of the register writeback
// arbiter. The "master" modport is the surrounding pipeline (producers of
// results, decode stage, register file) and the "slave" modport is the
// arbiter itself.
//
// Signals:
//   pipe_wr_en/sel/data      in-order pipeline result (no handshake)
//   ll_issue_en/sel          long-latency op issued, destination register
//   ll_valid/ready/sel/data  long-latency result offer, FIFO accept
//   rd_sel_ra/rb/rc          decode-stage source register selects
//   stall                    decode must hold
//   busy_mask                per-register "owed by long-latency unit" bits
//   ll_count                 long-latency FIFO occupancy
//   rf_write_en/sel/data     register-file write port
// ---------------------------------------------------------------------------
interface reg_write_back_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int LL_DEPTH   = 2
);

  localparam int CNT_WIDTH = $clog2(LL_DEPTH) + 1;

  logic                  pipe_wr_en;
  logic [SEL_WIDTH-1:0]  pipe_wr_sel;
  logic [DATA_WIDTH-1:0] pipe_wr_data;

  logic                  ll_issue_en;
  logic [SEL_WIDTH-1:0]  ll_issue_sel;

  logic                  ll_valid;
  logic                  ll_ready;
  logic [SEL_WIDTH-1:0]  ll_sel;
  logic [DATA_WIDTH-1:0] ll_data;

  logic [SEL_WIDTH-1:0]  rd_sel_ra;
  logic [SEL_WIDTH-1:0]  rd_sel_rb;
  logic [SEL_WIDTH-1:0]  rd_sel_rc;

  logic                  stall;
  logic [NUM_REGS-1:0]   busy_mask;
  logic [CNT_WIDTH-1:0]  ll_count;

  logic                  rf_write_en;
  logic [SEL_WIDTH-1:0]  rf_write_sel;
  logic [DATA_WIDTH-1:0] rf_write_data;

  modport master (
    output pipe_wr_en, pipe_wr_sel, pipe_wr_data,
    output ll_issue_en, ll_issue_sel,
    output ll_valid, ll_sel, ll_data,
    output rd_sel_ra, rd_sel_rb, rd_sel_rc,
    input  ll_ready, stall, busy_mask, ll_count,
    input  rf_write_en, rf_write_sel, rf_write_data
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_sel, pipe_wr_data,
    input  ll_issue_en, ll_issue_sel,
    input  ll_valid, ll_sel, ll_data,
    input  rd_sel_ra, rd_sel_rb, rd_sel_rc,
    output ll_ready, stall, busy_mask, ll_count,
    output rf_write_en, rf_write_sel, rf_write_data
  );

endinterface

// File: rtl/reg_write_back_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_back_arbiter
//
// Purpose: writeback stage driving the single register-file write port.
// The in-order pipeline result always wins; otherwise the oldest entry of a
// small long-latency result FIFO is popped and written. A busy scoreboard
// records registers still owed by long-latency units so decode can stall.
//
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of reg_write_back_arbiter_if (see interface header)
//
// Notes:
//   - rf_write_* are registered; sel/data hold when no write is issued.
//   - A winning write to register 0 is consumed but never enabled.
//   - ll_ready, stall and busy_mask depend only on registered state (and
//     rst / decode selects), never on ll_valid.
// ---------------------------------------------------------------------------
module reg_write_back_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int LL_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_write_back_arbiter_if.slave bus
);

  localparam int PTR_WIDTH = $clog2(LL_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(LL_DEPTH);
  localparam logic [NUM_REGS-1:0]  MASK_ZERO  = {NUM_REGS{1'b0}};
  localparam logic [NUM_REGS-1:0]  REG0_BIT   = NUM_REGS'(1);

  // ------------------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------------------
  function automatic logic sel_live(input logic [SEL_WIDTH-1:0] sel);
    return sel != {SEL_WIDTH{1'b0}};
  endfunction

  // A source operand blocks decode only if it names a real register whose
  // value is still owed by a long-latency unit.
  function automatic logic src_blocked(input logic [NUM_REGS-1:0]  mask,
                                       input logic [SEL_WIDTH-1:0] sel);
    return sel_live(sel) && mask[sel];
  endfunction

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [SEL_WIDTH-1:0]  fifo_sel_r  [LL_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [LL_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic [NUM_REGS-1:0]   busy_r;
  logic                  rf_en_r;
  logic [SEL_WIDTH-1:0]  rf_sel_r;
  logic [DATA_WIDTH-1:0] rf_data_r;

  // ------------------------------------------------------------------------
  // Combinational signals
  // ------------------------------------------------------------------------
  logic                  empty_s;
  logic                  full_s;
  logic                  ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic [SEL_WIDTH-1:0]  head_sel_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [CNT_WIDTH-1:0]  count_nxt_s;
  logic                  win_valid_s;
  logic [SEL_WIDTH-1:0]  win_sel_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic [NUM_REGS-1:0]   set_mask_s;
  logic [NUM_REGS-1:0]   clr_mask_s;
  logic [NUM_REGS-1:0]   busy_nxt_s;

  assign empty_s     = (count_r == CNT_ZERO);
  assign full_s      = (count_r == FULL_COUNT);
  // rst gates ready so nothing is accepted while the FIFO is held cleared.
  assign ready_s     = !rst && (count_r < FULL_COUNT);
  assign push_s      = bus.ll_valid && ready_s;
  // The pipeline has absolute priority; the FIFO only drains in its bubbles.
  assign pop_s       = !bus.pipe_wr_en && !empty_s;
  assign head_sel_s  = fifo_sel_r[rd_ptr_r];
  assign head_data_s = fifo_data_r[rd_ptr_r];

  // Occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Fixed-priority selection of the write-port winner for this cycle.
  always_comb begin
    win_valid_s = 1'b0;
    win_sel_s   = rf_sel_r;
    win_data_s  = rf_data_r;
    if (bus.pipe_wr_en) begin
      win_valid_s = 1'b1;
      win_sel_s   = bus.pipe_wr_sel;
      win_data_s  = bus.pipe_wr_data;
    end else if (pop_s) begin
      win_valid_s = 1'b1;
      win_sel_s   = head_sel_s;
      win_data_s  = head_data_s;
    end else begin
      win_valid_s = 1'b0;
      win_sel_s   = rf_sel_r;
      win_data_s  = rf_data_r;
    end
  end

  // Scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    set_mask_s = MASK_ZERO;
    clr_mask_s = MASK_ZERO;
    if (pop_s) begin
      clr_mask_s[head_sel_s] = 1'b1;
    end else begin
      clr_mask_s = MASK_ZERO;
    end
    if (bus.ll_issue_en && sel_live(bus.ll_issue_sel)) begin
      set_mask_s[bus.ll_issue_sel] = 1'b1;
    end else begin
      set_mask_s = MASK_ZERO;
    end
  end

  // Register 0 is hard zero, so its busy bit is forced clear.
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~REG0_BIT;

  // ------------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------------

  // Long-latency result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LL_DEPTH; i++) begin
        fifo_sel_r[i]  <= {SEL_WIDTH{1'b0}};
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_WIDTH{1'b0}};
      rd_ptr_r <= {PTR_WIDTH{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_sel_r[wr_ptr_r]  <= bus.ll_sel;
        fifo_data_r[wr_ptr_r] <= bus.ll_data;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= MASK_ZERO;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Register-file write port; sel/data only move when a winner exists.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en_r   <= 1'b0;
      rf_sel_r  <= {SEL_WIDTH{1'b0}};
      rf_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rf_en_r <= win_valid_s && sel_live(win_sel_s);
      if (win_valid_s) begin
        rf_sel_r  <= win_sel_s;
        rf_data_r <= win_data_s;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.ll_ready      = ready_s;
  assign bus.ll_count      = count_r;
  assign bus.busy_mask     = busy_r;
  // A full FIFO forces a decode bubble so the pipeline yields the port.
  assign bus.stall         = src_blocked(busy_r, bus.rd_sel_ra) ||
                             src_blocked(busy_r, bus.rd_sel_rb) ||
                             src_blocked(busy_r, bus.rd_sel_rc) ||
                             full_s;
  assign bus.rf_write_en   = rf_en_r;
  assign bus.rf_write_sel  = rf_sel_r;
  assign bus.rf_write_data = rf_data_r;

endmodule

// File: tb/tb_reg_write_back_arbiter.sv
module tb_reg_write_back_arbiter;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_write_back_arbiter_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .LL_DEPTH(D)) bus ();

  reg_write_back_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW), .LL_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: a plain queue of pending results, a busy bit per
  // register and the last value presented on the write port.
  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  bit            busy[NR];
  logic          m_en;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [NR-1:0] m_mask();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = busy[i];
    return r;
  endfunction

  function automatic logic m_blocked(input logic [SW-1:0] s);
    return (s != 0) && busy[s];
  endfunction

  function automatic logic m_stall();
    return m_blocked(bus.rd_sel_ra) || m_blocked(bus.rd_sel_rb) ||
           m_blocked(bus.rd_sel_rc) || (q.size() == D);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NR; i++) busy[i] = 0;
    m_en = 1'b0;
    m_sel = '0;
    m_data = '0;
  endtask

  task automatic drive_idle();
    bus.pipe_wr_en = 1'b0;  bus.pipe_wr_sel = '0;  bus.pipe_wr_data = '0;
    bus.ll_issue_en = 1'b0; bus.ll_issue_sel = '0;
    bus.ll_valid = 1'b0;    bus.ll_sel = '0;       bus.ll_data = '0;
    bus.rd_sel_ra = '0;     bus.rd_sel_rb = '0;    bus.rd_sel_rc = '0;
  endtask

  // One clock: apply the writeback rules to the model at the edge, then
  // settle 1 time unit past the edge for sampling.
  task automatic cycle();
    ent_t e;
    bit   rdy;
    rdy = !rst && (q.size() < D);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (bus.pipe_wr_en) begin
        m_en = (bus.pipe_wr_sel != 0);
        m_sel = bus.pipe_wr_sel;
        m_data = bus.pipe_wr_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_en = (e.sel != 0);
        m_sel = e.sel;
        m_data = e.data;
        busy[e.sel] = 0;
      end else begin
        m_en = 1'b0;
      end
      if (bus.ll_issue_en && bus.ll_issue_sel != 0) busy[bus.ll_issue_sel] = 1;
      if (bus.ll_valid && rdy) begin
        e.sel = bus.ll_sel;
        e.data = bus.ll_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) cycle();
    vectors += 7;
    if (bus.rf_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %0b want 0", bus.rf_write_en); end
    if (bus.rf_write_sel !== '0) begin miscompares++; $display("FAIL reset_sel got %0h want 0", bus.rf_write_sel); end
    if (bus.rf_write_data !== '0) begin miscompares++; $display("FAIL reset_data got %0h want 0", bus.rf_write_data); end
    if (bus.busy_mask !== '0) begin miscompares++; $display("FAIL reset_busy got %0h want 0", bus.busy_mask); end
    if (bus.ll_count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.ll_count); end
    if (bus.ll_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %0b want 0", bus.ll_ready); end
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %0b want 0", bus.stall); end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.ll_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready got %0b want 1", bus.ll_ready); end
    // Build up traffic, then reset in the middle of it.
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd9;
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd9; bus.ll_data = 32'h0000_9999;
    cycle();
    drive_idle();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_sel = 4'd2; bus.pipe_wr_data = 32'h0000_2222;
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd10;
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd10; bus.ll_data = 32'h0000_AAAA;
    cycle();
    vectors += 3;
    if (bus.ll_count !== 2'd2) begin miscompares++; $display("FAIL pre_rst_count got %0d want 2", bus.ll_count); end
    if (bus.busy_mask !== 16'h0600) begin miscompares++; $display("FAIL pre_rst_busy got %0h want 0600", bus.busy_mask); end
    if (bus.rf_write_en !== 1'b1) begin miscompares++; $display("FAIL pre_rst_en got %0b want 1", bus.rf_write_en); end
    drive_idle();
    rst = 1'b1;
    #2;
    model_reset();
    vectors += 4;
    if (bus.rf_write_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en got %0b want 0", bus.rf_write_en); end
    if (bus.busy_mask !== '0) begin miscompares++; $display("FAIL mid_rst_busy got %0h want 0", bus.busy_mask); end
    if (bus.ll_count !== '0) begin miscompares++; $display("FAIL mid_rst_count got %0d want 0", bus.ll_count); end
    if (bus.ll_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %0b want 0", bus.ll_ready); end
    cycle();
    rst = 1'b0;
    cycle();
    vectors += 3;
    if (bus.rf_write_en !== 1'b0) begin miscompares++; $display("FAIL post_rst_en got %0b want 0", bus.rf_write_en); end
    if (bus.ll_count !== '0) begin miscompares++; $display("FAIL post_rst_count got %0d want 0", bus.ll_count); end
    if (bus.ll_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %0b want 1", bus.ll_ready); end
  endtask

  task automatic test_pipe_priority();
    logic [DW-1:0] pd;
    drive_idle();
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd3; bus.ll_data = 32'hDEAD_BEEF;
    cycle();
    vectors++;
    if (bus.ll_count !== 2'd1) begin miscompares++; $display("FAIL prio_push_count got %0d want 1", bus.ll_count); end
    for (int k = 0; k < 3; k++) begin
      pd = 32'h11 * (k + 1);
      drive_idle();
      bus.pipe_wr_en = 1'b1; bus.pipe_wr_sel = 4'd5; bus.pipe_wr_data = pd;
      cycle();
      vectors += 4;
      if (bus.rf_write_en !== 1'b1) begin miscompares++; $display("FAIL prio_pipe_en[%0d] got %0b want 1", k, bus.rf_write_en); end
      if (bus.rf_write_sel !== 4'd5) begin miscompares++; $display("FAIL prio_pipe_sel[%0d] got %0d want 5", k, bus.rf_write_sel); end
      if (bus.rf_write_data !== pd) begin miscompares++; $display("FAIL prio_pipe_data[%0d] got %0h want %0h", k, bus.rf_write_data, pd); end
      if (bus.ll_count !== 2'd1) begin miscompares++; $display("FAIL prio_hold_count[%0d] got %0d want 1", k, bus.ll_count); end
    end
    drive_idle();
    cycle();
    vectors += 4;
    if (bus.rf_write_en !== 1'b1) begin miscompares++; $display("FAIL prio_ll_en got %0b want 1", bus.rf_write_en); end
    if (bus.rf_write_sel !== 4'd3) begin miscompares++; $display("FAIL prio_ll_sel got %0d want 3", bus.rf_write_sel); end
    if (bus.rf_write_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL prio_ll_data got %0h want deadbeef", bus.rf_write_data); end
    if (bus.ll_count !== 2'd0) begin miscompares++; $display("FAIL prio_pop_count got %0d want 0", bus.ll_count); end
    cycle();
    vectors += 3;
    if (bus.rf_write_en !== 1'b0) begin miscompares++; $display("FAIL prio_idle_en got %0b want 0", bus.rf_write_en); end
    if (bus.rf_write_sel !== 4'd3) begin miscompares++; $display("FAIL prio_hold_sel got %0d want 3", bus.rf_write_sel); end
    if (bus.rf_write_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL prio_hold_data got %0h want deadbeef", bus.rf_write_data); end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd7; bus.rd_sel_rb = 4'd7;
    cycle();
    bus.ll_issue_en = 1'b0;
    #1;
    vectors += 2;
    if (bus.busy_mask !== 16'h0080) begin miscompares++; $display("FAIL sb_set got %0h want 0080", bus.busy_mask); end
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sb_stall got %0b want 1", bus.stall); end
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd7; bus.ll_data = 32'h0000_0077;
    cycle();
    bus.ll_valid = 1'b0;
    #1;
    vectors += 2;
    if (bus.ll_count !== 2'd1) begin miscompares++; $display("FAIL sb_push_count got %0d want 1", bus.ll_count); end
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sb_stall_pending got %0b want 1", bus.stall); end
    cycle();
    vectors += 4;
    if (bus.busy_mask !== 16'h0000) begin miscompares++; $display("FAIL sb_clear got %0h want 0", bus.busy_mask); end
    if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL sb_unstall got %0b want 0", bus.stall); end
    if (bus.rf_write_sel !== 4'd7) begin miscompares++; $display("FAIL sb_wr_sel got %0d want 7", bus.rf_write_sel); end
    if (bus.rf_write_data !== 32'h77) begin miscompares++; $display("FAIL sb_wr_data got %0h want 77", bus.rf_write_data); end
    // Same-cycle issue and pop of register 7: set wins.
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd7;
    cycle();
    bus.ll_issue_en = 1'b0;
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd7; bus.ll_data = 32'h0000_0078;
    cycle();
    bus.ll_valid = 1'b0;
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd7;
    cycle();
    bus.ll_issue_en = 1'b0;
    #1;
    vectors += 3;
    if (bus.busy_mask !== 16'h0080) begin miscompares++; $display("FAIL sb_set_wins got %0h want 0080", bus.busy_mask); end
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL sb_set_wins_stall got %0b want 1", bus.stall); end
    if (bus.rf_write_data !== 32'h78) begin miscompares++; $display("FAIL sb_pop_data got %0h want 78", bus.rf_write_data); end
    bus.ll_valid = 1'b1; bus.ll_data = 32'h0000_0079;
    cycle();
    drive_idle();
    cycle();
    vectors++;
    if (bus.busy_mask !== 16'h0000) begin miscompares++; $display("FAIL sb_final got %0h want 0", bus.busy_mask); end
  endtask

  task automatic test_fifo_full();
    drive_idle();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_sel = 4'd1; bus.pipe_wr_data = $urandom;
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd4; bus.ll_data = 32'hA000_0001;
    cycle();
    bus.pipe_wr_data = $urandom; bus.ll_data = 32'hB000_0002;
    cycle();
    vectors += 3;
    if (bus.ll_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %0b want 0", bus.ll_ready); end
    if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL full_stall got %0b want 1", bus.stall); end
    if (bus.ll_count !== 2'd2) begin miscompares++; $display("FAIL full_count got %0d want 2", bus.ll_count); end
    bus.pipe_wr_data = $urandom; bus.ll_sel = 4'd6; bus.ll_data = 32'hC000_0003;
    cycle();
    vectors += 2;
    if (bus.ll_count !== 2'd2) begin miscompares++; $display("FAIL full_held_count got %0d want 2", bus.ll_count); end
    if (bus.ll_ready !== 1'b0) begin miscompares++; $display("FAIL full_held_ready got %0b want 0", bus.ll_ready); end
    bus.pipe_wr_en = 1'b0;
    cycle();
    vectors += 3;
    if (bus.ll_count !== 2'd1) begin miscompares++; $display("FAIL bubble_count got %0d want 1", bus.ll_count); end
    if (bus.ll_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_ready got %0b want 1", bus.ll_ready); end
    if (bus.rf_write_data !== 32'hA000_0001) begin miscompares++; $display("FAIL bubble_data got %0h want a0000001", bus.rf_write_data); end
    cycle();
    bus.ll_valid = 1'b0;
    #1;
    vectors += 2;
    if (bus.ll_count !== 2'd1) begin miscompares++; $display("FAIL pushpop_count got %0d want 1", bus.ll_count); end
    if (bus.rf_write_data !== 32'hB000_0002) begin miscompares++; $display("FAIL second_data got %0h want b0000002", bus.rf_write_data); end
    cycle();
    vectors += 3;
    if (bus.rf_write_data !== 32'hC000_0003) begin miscompares++; $display("FAIL third_data got %0h want c0000003", bus.rf_write_data); end
    if (bus.rf_write_sel !== 4'd6) begin miscompares++; $display("FAIL third_sel got %0d want 6", bus.rf_write_sel); end
    if (bus.ll_count !== 2'd0) begin miscompares++; $display("FAIL drain_count got %0d want 0", bus.ll_count); end
  endtask

  task automatic test_zero_reg();
    drive_idle();
    bus.pipe_wr_en = 1'b1; bus.pipe_wr_sel = 4'd0; bus.pipe_wr_data = $urandom;
    bus.ll_valid = 1'b1; bus.ll_sel = 4'd0; bus.ll_data = $urandom;
    bus.ll_issue_en = 1'b1; bus.ll_issue_sel = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) drive_idle();
      cycle();
      vectors += 2;
      if (bus.rf_write_en !== 1'b0) begin miscompares++; $display("FAIL zero_en[%0d] got %0b want 0", k, bus.rf_write_en); end
      if (bus.busy_mask !== 16'h0000) begin miscompares++; $display("FAIL zero_busy[%0d] got %0h want 0", k, bus.busy_mask); end
    end
    vectors++;
    if (bus.ll_count !== 2'd0) begin miscompares++; $display("FAIL zero_drain got %0d want 0", bus.ll_count); end
  endtask

  task automatic test_wrap();
    drive_idle();
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        bus.ll_valid = 1'b1; bus.ll_sel = SW'(k); bus.ll_data = DW'(k);
      end else begin
        bus.ll_valid = 1'b0;
      end
      cycle();
      if (k >= 2) begin
        vectors += 3;
        if (bus.rf_write_en !== 1'b1) begin miscompares++; $display("FAIL wrap_en[%0d] got %0b want 1", k, bus.rf_write_en); end
        if (bus.rf_write_data !== DW'(k - 1)) begin miscompares++; $display("FAIL wrap_data[%0d] got %0h want %0h", k, bus.rf_write_data, k - 1); end
        if (bus.ll_count !== ((k <= 8) ? 2'd1 : 2'd0)) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d", k, bus.ll_count); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      bus.pipe_wr_en = ($urandom_range(0, 2) == 0);
      bus.pipe_wr_sel = SW'($urandom);  bus.pipe_wr_data = $urandom;
      bus.ll_issue_en = $urandom_range(0, 1); bus.ll_issue_sel = SW'($urandom);
      bus.ll_valid = $urandom_range(0, 1); bus.ll_sel = SW'($urandom); bus.ll_data = $urandom;
      bus.rd_sel_ra = SW'($urandom); bus.rd_sel_rb = SW'($urandom); bus.rd_sel_rc = SW'($urandom);
      cycle();
      vectors += 5;
      if (bus.rf_write_en !== m_en) begin miscompares++; $display("FAIL rnd_en[%0d] got %0b want %0b", n, bus.rf_write_en, m_en); end
      if (bus.busy_mask !== m_mask()) begin miscompares++; $display("FAIL rnd_busy[%0d] got %0h want %0h", n, bus.busy_mask, m_mask()); end
      if (bus.ll_count !== CW'(q.size())) begin miscompares++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.ll_count, q.size()); end
      if (bus.ll_ready !== (!rst && q.size() < D)) begin miscompares++; $display("FAIL rnd_ready[%0d] got %0b", n, bus.ll_ready); end
      if (bus.stall !== m_stall()) begin miscompares++; $display("FAIL rnd_stall[%0d] got %0b want %0b", n, bus.stall, m_stall()); end
      if (m_en) begin
        vectors += 2;
        if (bus.rf_write_sel !== m_sel) begin miscompares++; $display("FAIL rnd_sel[%0d] got %0d want %0d", n, bus.rf_write_sel, m_sel); end
        if (bus.rf_write_data !== m_data) begin miscompares++; $display("FAIL rnd_data[%0d] got %0h want %0h", n, bus.rf_write_data, m_data); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    drive_idle();
    #1;
    test_reset();
    test_pipe_priority();
    test_scoreboard();
    test_fifo_full();
    test_zero_reg();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_write_back_arbiter.md
# reg_write_back_arbiter

Writeback stage that sits directly upstream of the register file and drives its single write port. Merges the in-order pipeline result with out-of-order results from long-latency units (divider, multiplier, loads) held in a small FIFO. Keeps a per-register busy scoreboard so the decode stage can stall on operands still owed by a long-latency unit.

## Interface

Parameters:
- DATA_WIDTH, 32, register data width
- NUM_REGS, 16, architectural registers; register 0 is hard zero
- SEL_WIDTH, 4, register index width ($clog2(NUM_REGS))
- LL_DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pipe_wr_en  in  1  pipeline writeback valid (always accepted, no handshake)
- pipe_wr_sel  in  SEL_WIDTH  pipeline destination register
- pipe_wr_data  in  DATA_WIDTH  pipeline result
- ll_issue_en  in  1  a long-latency op issued this cycle
- ll_issue_sel  in  SEL_WIDTH  its destination register
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  FIFO can accept; transfer when ll_valid && ll_ready
- ll_sel  in  SEL_WIDTH  long-latency result destination
- ll_data  in  DATA_WIDTH  long-latency result data
- rd_sel_ra, rd_sel_rb, rd_sel_rc  in  SEL_WIDTH each  decode-stage source selects
- stall  out  1  decode must hold
- busy_mask  out  NUM_REGS  scoreboard, bit i = register i owed by long-latency unit
- ll_count  out  $clog2(LL_DEPTH)+1  FIFO occupancy
- rf_write_en  out  1  register-file write enable
- rf_write_sel  out  SEL_WIDTH  register-file write index
- rf_write_data  out  DATA_WIDTH  register-file write data

## Operation

- Reset (async assert): rf_write_en/sel/data = 0, busy_mask = 0, FIFO empty, ll_count = 0; ll_ready = 0 while rst high, stall follows its combinational equation on the cleared state (0 unless FIFO-full term applies, which it cannot).
- FIFO: push on ll_valid && ll_ready; ll_ready = !rst && (ll_count < LL_DEPTH). Pointers wrap modulo LL_DEPTH. Push and pop in the same cycle legal at any occupancy where each is individually allowed; count unchanged.
- Arbitration each cycle, fixed priority:
  - pipe_wr_en = 1: register pipe write to rf_write_*; FIFO not popped.
  - else FIFO non-empty: pop head, register it to rf_write_*.
  - else rf_write_en <= 0; rf_write_sel/data hold previous values.
- Zero register: any winning write with sel = 0 registers rf_write_en = 0 (FIFO still popped if it was the winner).
- Scoreboard: ll_issue_en with ll_issue_sel ≠ 0 sets that bit; FIFO pop clears bit ll_sel of popped entry. Set and clear of the same bit in one cycle → set wins. Issue to an already-busy register leaves bit 1. Pipe writes never touch busy_mask.
- stall (combinational) = (busy_mask[rd_sel_ra] && rd_sel_ra ≠ 0) || same for rb || same for rc || (ll_count == LL_DEPTH). FIFO-full term guarantees pipeline bubbles so the FIFO drains.
- No direct ll → rf bypass; every long-latency result passes through the FIFO.

## Timing

- Pipe write: inputs at edge N → rf_write_* valid in cycle N..N+1, committed in register file at edge N+1.
- Long-latency write: accepted at edge N → earliest pop at edge N+1 (if no pipe write) → committed at edge N+2.
- Busy bit clears at the pop edge; during the following cycle the register file's write-to-read forwarding supplies the data, so stall may drop that same cycle.
- ll_ready, stall, busy_mask reflect registered state; no combinational path from ll_valid to ll_ready.
- rst asserted mid-operation: FIFO contents and pending busy bits discarded immediately; no write issued after deassert until new input.

## Test plan

- Reset: assert rst mid-traffic → rf_write_en = 0, busy_mask = 0, ll_count = 0, ll_ready = 0; after release ll_ready = 1.
- Pipe priority: ll push (sel 3, data 0xDEAD_BEEF) then 3 consecutive pipe writes (sel 5, 0x11/0x22/0x33) → rf writes 5,5,5 then 3 = 0xDEAD_BEEF one cycle later; ll_count 1 until pop.
- Scoreboard/stall: issue sel 7, rd_sel_rb = 7 → stall = 1; ll result sel 7 → busy_mask[7] clears at pop edge, stall = 0 next cycle; same-cycle issue and pop of sel 7 → bit stays 1.
- FIFO full: continuous pipe writes, push 2 ll results → ll_ready = 0, stall = 1, third ll_valid held; pipe bubble → pop, ll_ready = 1.
- Zero register: pipe_wr_sel = 0 and ll_sel = 0 results → rf_write_en never 1; FIFO still drains to ll_count = 0; issue to sel 0 leaves busy_mask = 0.
- Simultaneous push/pop at count 1 → count stays 1, data order preserved across pointer wrap (8 results in sequence 0x1..0x8 written in order).
